// File: rtl/vdp_pkg.sv
// Shared definitions for the CPU-to-VDP bus bridge: FSM states, CPU port codes
// and the layout of a queued write entry.
package vdp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_GAP,
    ST_DRAIN,
    ST_READ,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    PORT_RD_DATA   = 2'd0,
    PORT_RD_STATUS = 2'd1,
    PORT_WR_DATA   = 2'd2,
    PORT_WR_ADDR   = 2'd3
  } cpu_port_t;

  localparam int unsigned ENTRY_W = 9;

  typedef struct packed {
    logic       mode;
    logic [7:0] data;
  } wr_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head output; push and pop may coincide.
module sync_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/vdp_bus_bridge.sv
// Bridges 8-bit CPU port strobes to a VDP: queues writes with forced gaps and
// serialises reads behind all queued writes.
module vdp_bus_bridge
  import vdp_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned WR_GAP     = 2,
  parameter int unsigned RD_CYCLES  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  cpu_port,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_rvalid,
  output logic        cpu_ready,
  output logic        overflow,
  output logic        vdp_mode,
  output logic [7:0]  vdp_addr,
  output logic [7:0]  vdp_data_in,
  output logic        vdp_wr,
  output logic        vdp_rd,
  input  logic [15:0] vdp_data_out
);

  state_t     state, state_nx;
  logic [7:0] cnt;
  logic       rd_pend, rd_mode;
  logic       mode_q;
  logic [7:0] data_q, rdata_q;
  logic       wr_req, rd_req, push, rd_accept;
  logic       pop, load_wr, load_rd, capture;
  logic       fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] fifo_dout;
  wr_entry_t  head;
  logic [7:0] unused_lo;

  assign unused_lo = vdp_data_out[7:0];
  assign head      = wr_entry_t'(fifo_dout);

  assign wr_req    = cpu_wr && (cpu_port == PORT_WR_DATA || cpu_port == PORT_WR_ADDR);
  assign rd_req    = cpu_rd && (cpu_port == PORT_RD_DATA || cpu_port == PORT_RD_STATUS);
  assign cpu_ready = !fifo_full && !rd_pend;
  assign push      = wr_req && cpu_ready;
  assign rd_accept = rd_req && cpu_ready;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   ({cpu_port[0], cpu_wdata}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The head entry keeps its slot until its gap ends, so a pending write still
  // counts towards "full" while it is on the VDP bus.
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    load_wr  = 1'b0;
    load_rd  = 1'b0;
    capture  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          load_wr  = 1'b1;
          state_nx = ST_WRITE;
        end else if (rd_pend) begin
          load_rd  = 1'b1;
          state_nx = ST_READ;
        end
      end
      ST_WRITE: state_nx = ST_GAP;
      ST_GAP: begin
        if (cnt == 8'(WR_GAP - 1)) begin
          pop      = 1'b1;
          state_nx = rd_pend ? ST_DRAIN : ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (!fifo_empty) begin
          load_wr  = 1'b1;
          state_nx = ST_WRITE;
        end else begin
          load_rd  = 1'b1;
          state_nx = ST_READ;
        end
      end
      ST_READ: begin
        if (cnt == 8'(RD_CYCLES - 1)) begin
          capture  = 1'b1;
          state_nx = ST_DONE;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      rd_pend  <= 1'b0;
      rd_mode  <= 1'b0;
      overflow <= 1'b0;
      mode_q   <= 1'b0;
      data_q   <= '0;
      rdata_q  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= (state_nx != state) ? '0 : cnt + 8'd1;
      if (rd_accept) begin
        rd_pend <= 1'b1;
        rd_mode <= cpu_port[0];
      end else if (state == ST_DONE) begin
        rd_pend <= 1'b0;
      end
      if ((wr_req || rd_req) && !cpu_ready) overflow <= 1'b1;
      if (load_wr) begin
        mode_q <= head.mode;
        data_q <= head.data;
      end else if (load_rd) begin
        mode_q <= rd_mode;
      end
      if (capture) rdata_q <= vdp_data_out[15:8];
    end
  end

  assign vdp_wr      = (state == ST_WRITE);
  assign vdp_rd      = (state == ST_READ);
  assign cpu_rvalid  = (state == ST_DONE);
  assign cpu_rdata   = rdata_q;
  assign vdp_mode    = mode_q;
  assign vdp_data_in = data_q;
  assign vdp_addr    = '0;

endmodule

// File: tb/tb_vdp_bus_bridge.sv
// Self-checking bench for vdp_bus_bridge: directed scenarios plus random traffic
// against a VDP memory/address reference model.
module tb_vdp_bus_bridge;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned GAP   = 2;
  localparam int unsigned RDC   = 4;
  localparam logic [7:0]  STATUS = 8'h80;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  cpu_port;
  logic        cpu_wr, cpu_rd;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        cpu_rvalid, cpu_ready, overflow, vdp_mode, vdp_wr, vdp_rd;
  logic [7:0]  vdp_addr, vdp_data_in;
  logic [15:0] vdp_data_out;

  always #20 clk = ~clk;

  vdp_bus_bridge #(
    .FIFO_DEPTH (DEPTH),
    .WR_GAP     (GAP),
    .RD_CYCLES  (RDC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_port     (cpu_port),
    .cpu_wr       (cpu_wr),
    .cpu_rd       (cpu_rd),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .cpu_rvalid   (cpu_rvalid),
    .cpu_ready    (cpu_ready),
    .overflow     (overflow),
    .vdp_mode     (vdp_mode),
    .vdp_addr     (vdp_addr),
    .vdp_data_in  (vdp_data_in),
    .vdp_wr       (vdp_wr),
    .vdp_rd       (vdp_rd),
    .vdp_data_out (vdp_data_out)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: what the VDP should end up seeing, derived from CPU traffic.
  logic [7:0]  ref_mem [16384];
  logic [13:0] ref_addr;
  logic [7:0]  ref_lo;
  bit          ref_latch;
  logic [8:0]  exp_wr_q[$];
  logic [7:0]  exp_rd_q[$];
  logic        exp_mode_q[$];

  function automatic void ref_write(input logic mode, input logic [7:0] d);
    if (mode) begin
      if (!ref_latch) begin ref_lo = d; ref_latch = 1'b1; end
      else begin ref_addr = {d[5:0], ref_lo}; ref_latch = 1'b0; end
    end else begin
      ref_mem[ref_addr] = d;
      ref_addr = ref_addr + 14'd1;
      ref_latch = 1'b0;
    end
  endfunction

  function automatic logic [7:0] ref_read(input logic mode);
    logic [7:0] r;
    ref_latch = 1'b0;
    if (mode) r = STATUS;
    else begin r = ref_mem[ref_addr]; ref_addr = ref_addr + 14'd1; end
    return r;
  endfunction

  // VDP device model driven purely by the DUT's VDP-side pins.
  logic [7:0]  vmem [16384];
  logic [13:0] vaddr;
  logic [7:0]  vlo, junk;
  bit          vlatch;
  logic        prev_rd, prev_mode;

  assign vdp_data_out = {vdp_mode ? STATUS : vmem[vaddr], junk};

  always @(posedge clk) begin
    junk      <= 8'($urandom);
    prev_rd   <= vdp_rd;
    prev_mode <= vdp_mode;
    if (reset) begin
      vlatch <= 1'b0;
      vaddr  <= '0;
    end else begin
      if (vdp_wr) begin
        if (vdp_mode) begin
          if (!vlatch) begin vlo <= vdp_data_in; vlatch <= 1'b1; end
          else begin vaddr <= {vdp_data_in[5:0], vlo}; vlatch <= 1'b0; end
        end else begin
          vmem[vaddr] <= vdp_data_in;
          vaddr  <= vaddr + 14'd1;
          vlatch <= 1'b0;
        end
      end
      if (prev_rd && !vdp_rd) begin
        vlatch <= 1'b0;
        if (!prev_mode) vaddr <= vaddr + 14'd1;
      end
    end
  end

  // Bus monitor: checks every VDP pulse and read completion against the model.
  int wr_pulses = 0, rvalid_cnt = 0;
  int last_wr_cyc = 0, prev_wr_cyc = 0, rvalid_cyc = 0;
  logic [7:0] last_rdata;
  logic mon_prev_rd = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (vdp_wr) begin
        wr_pulses++;
        prev_wr_cyc = last_wr_cyc;
        last_wr_cyc = cyc;
        if (exp_wr_q.size() == 0) chk("vdp_wr_expected", 16'(exp_wr_q.size() != 0), 16'd1);
        else chk("vdp_wr_entry", {7'd0, vdp_mode, vdp_data_in}, {7'd0, exp_wr_q.pop_front()});
      end
      if (vdp_rd) begin
        if (exp_mode_q.size() == 0) chk("vdp_rd_expected", 16'(exp_mode_q.size() != 0), 16'd1);
        else chk("rd_mode", {15'd0, vdp_mode}, {15'd0, exp_mode_q[0]});
        if (!mon_prev_rd) chk("writes_drained_before_rd", 16'(exp_wr_q.size()), 16'd0);
      end
      if (cpu_rvalid) begin
        rvalid_cnt++;
        rvalid_cyc = cyc;
        last_rdata = cpu_rdata;
        if (exp_rd_q.size() == 0) chk("rvalid_expected", 16'(exp_rd_q.size() != 0), 16'd1);
        else begin
          chk("cpu_rdata", {8'd0, cpu_rdata}, {8'd0, exp_rd_q.pop_front()});
          void'(exp_mode_q.pop_front());
        end
      end
    end
    mon_prev_rd = vdp_rd;
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive(input bit is_wr, input logic [1:0] port, input logic [7:0] d);
    cpu_port = port; cpu_wr = is_wr; cpu_rd = !is_wr; cpu_wdata = d;
    step(1);
    cpu_wr = 1'b0; cpu_rd = 1'b0;
  endtask

  task automatic issue(input bit is_wr, input logic [1:0] port, input logic [7:0] d);
    if (is_wr) begin
      if (port[1]) begin
        exp_wr_q.push_back({port[0], d});
        ref_write(port[0], d);
      end
    end else if (!port[1]) begin
      exp_mode_q.push_back(port[0]);
      exp_rd_q.push_back(ref_read(port[0]));
    end
    drive(is_wr, port, d);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!cpu_ready && n < 200) begin step(1); n++; end
    chk(tag, {15'd0, cpu_ready}, 16'd1);
  endtask

  task automatic wait_quiet(input string tag);
    int n = 0;
    while ((exp_wr_q.size() != 0 || exp_rd_q.size() != 0 || !cpu_ready) && n < 3000) begin
      step(1); n++;
    end
    step(3);
    chk(tag, 16'(exp_wr_q.size() + exp_rd_q.size()), 16'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"},    {15'd0, cpu_ready},   16'd1);
    chk({tag, "_rvalid"},   {15'd0, cpu_rvalid},  16'd0);
    chk({tag, "_rdata"},    {8'd0, cpu_rdata},    16'd0);
    chk({tag, "_overflow"}, {15'd0, overflow},    16'd0);
    chk({tag, "_vdp_wr"},   {15'd0, vdp_wr},      16'd0);
    chk({tag, "_vdp_rd"},   {15'd0, vdp_rd},      16'd0);
    chk({tag, "_mode"},     {15'd0, vdp_mode},    16'd0);
    chk({tag, "_data_in"},  {8'd0, vdp_data_in},  16'd0);
    chk({tag, "_addr"},     {8'd0, vdp_addr},     16'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, p0, r0, n;
    cpu_port = '0; cpu_wr = 1'b0; cpu_rd = 1'b0; cpu_wdata = '0;
    ref_addr = '0; ref_lo = '0; ref_latch = 1'b0;
    for (int i = 0; i < 16384; i++) begin
      ref_mem[i] = 8'(i) ^ 8'hA5;
      vmem[i]    = 8'(i) ^ 8'hA5;
    end
    reset = 1'b1;
    step(3);
    check_reset_vals("reset");
    reset = 1'b0;
    step(2);

    // Address/register pair: pulse spacing is the forced gap plus the idle cycle.
    issue(1'b1, 2'd3, 8'h00);
    issue(1'b1, 2'd3, 8'h80);
    wait_quiet("drain_pair");
    chk("wr_pulse_spacing", 16'(last_wr_cyc - prev_wr_cyc), 16'(GAP + 2));

    // Set write address 0x1234, write two bytes, read them back.
    issue(1'b1, 2'd3, 8'h34);
    issue(1'b1, 2'd3, 8'h52);
    issue(1'b1, 2'd2, 8'h5A);
    issue(1'b1, 2'd2, 8'hEE);
    wait_quiet("drain_mem_write");
    issue(1'b1, 2'd3, 8'h34);
    issue(1'b1, 2'd3, 8'h12);
    wait_ready("ready_before_read1");
    issue(1'b0, 2'd0, 8'h00);
    wait_quiet("readback1");
    chk("readback_5A", {8'd0, last_rdata}, 16'h005A);
    issue(1'b0, 2'd0, 8'h00);
    wait_quiet("readback2");
    chk("readback_EE", {8'd0, last_rdata}, 16'h00EE);

    // Writes to read ports are ignored and never flag overflow, even when busy.
    drive(1'b1, 2'd0, 8'hFF);
    step(6);
    chk("ignored_wr_no_overflow", {15'd0, overflow}, 16'd0);

    // Status read: latency and mode.
    s = cyc;
    issue(1'b0, 2'd1, 8'h00);
    drive(1'b1, 2'd1, 8'hFF);
    wait_quiet("status_read");
    chk("rd_latency", 16'(rvalid_cyc - s), 16'(RDC + 2));
    chk("status_byte", {8'd0, last_rdata}, {8'd0, STATUS});
    chk("ignored_wr_busy_no_overflow", {15'd0, overflow}, 16'd0);

    // Write immediately followed by a read: read must wait for the write.
    issue(1'b1, 2'd2, 8'h11);
    chk("ready_after_one_wr", {15'd0, cpu_ready}, 16'd1);
    issue(1'b0, 2'd0, 8'h00);
    wait_quiet("wr_then_rd");

    // Five back-to-back data writes into a four-entry queue.
    p0 = wr_pulses;
    for (int i = 0; i < 5; i++) begin
      chk("ready_back_to_back", {15'd0, cpu_ready}, (i < 4) ? 16'd1 : 16'd0);
      if (i < 4) issue(1'b1, 2'd2, 8'($urandom));
      else       drive(1'b1, 2'd2, 8'($urandom));
    end
    wait_quiet("overflow_drain");
    step(10);
    chk("four_pulses", 16'(wr_pulses - p0), 16'd4);
    chk("overflow_set", {15'd0, overflow}, 16'd1);

    // Reset in the middle of a read, with strobes arriving while busy.
    issue(1'b0, 2'd0, 8'h00);
    n = 0;
    while (!vdp_rd && n < 50) begin step(1); n++; end
    chk("read_started", {15'd0, vdp_rd}, 16'd1);
    drive(1'b1, 2'd2, 8'h77);
    drive(1'b1, 2'd3, 8'h78);
    #5 reset = 1'b1;
    #1 check_reset_vals("async_reset");
    exp_wr_q.delete(); exp_rd_q.delete(); exp_mode_q.delete();
    ref_addr = '0; ref_latch = 1'b0;
    step(2);
    reset = 1'b0;
    p0 = wr_pulses; r0 = rvalid_cnt;
    step(20);
    chk("no_wr_after_reset", 16'(wr_pulses - p0), 16'd0);
    chk("no_rvalid_after_reset", 16'(rvalid_cnt - r0), 16'd0);

    // Random traffic against the reference model.
    for (int i = 0; i < 80; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      wait_ready("ready_random");
      if (r < 45) issue(1'b1, 2'd2, 8'($urandom));
      else if (r < 60) begin
        issue(1'b1, 2'd3, 8'($urandom));
        wait_ready("ready_random_pair");
        issue(1'b1, 2'd3, 8'($urandom));
      end else issue(1'b0, 2'($urandom_range(0, 1)), 8'h00);
      step(int'($urandom_range(0, 3)));
    end
    wait_quiet("random_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
